// File: rtl/add_seq_pkg.sv
// Shared types, defaults and parameter derivations for the sliced ripple-carry add sequencer.
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DATA_W_DEF  = 64;
    localparam int unsigned SLICE_W_DEF = 16;

    function automatic int unsigned num_slices(input int unsigned data_w, input int unsigned slice_w);
        return data_w / slice_w;
    endfunction

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int unsigned idx_w(input int unsigned n_slices);
        return (n_slices <= 1) ? 1 : $clog2(n_slices);
    endfunction

    function automatic bit slices_ok(input int unsigned data_w, input int unsigned slice_w);
        return (slice_w != 0) && (data_w >= slice_w) && ((data_w % slice_w) == 0);
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Purely combinational W-bit ripple-carry adder built from a chain of full adders.
module rca_slice #(
    parameter int unsigned W = 16
) (
    output logic         c_out,
    output logic [W-1:0] sum,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in
);

    logic [W:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[W];

endmodule

// File: rtl/rca_add_sequencer.sv
// Multi-cycle DATA_W-bit adder: one SLICE_W ripple slice reused per cycle, LSB slice first.
// Optional subtract mode (op_sub port) is enabled by defining ADD_SEQ_SUB_EN.
module rca_add_sequencer
    import add_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SLICE_W = SLICE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              c_in,
`ifdef ADD_SEQ_SUB_EN
    input  logic              op_sub,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              c_out,
    output logic              busy
);

    localparam int unsigned NUM_SLICES = num_slices(DATA_W, SLICE_W);
    localparam int unsigned IDX_W      = idx_w(NUM_SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    if (!slices_ok(DATA_W, SLICE_W)) begin : g_bad_cfg
        $error("rca_add_sequencer: DATA_W must be a nonzero multiple of SLICE_W");
    end

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  a_r;
    logic [DATA_W-1:0]  b_r;
    logic               carry;

    logic [DATA_W-1:0]  b_in;
    logic               carry_in;
    logic [SLICE_W-1:0] a_s;
    logic [SLICE_W-1:0] b_s;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_c;

    // Subtraction is a + ~b + 1, so the operand is inverted once at capture time.
`ifdef ADD_SEQ_SUB_EN
    assign b_in     = op_sub ? ~b : b;
    assign carry_in = op_sub ? 1'b1 : c_in;
`else
    assign b_in     = b;
    assign carry_in = c_in;
`endif

    assign a_s = a_r[idx*SLICE_W +: SLICE_W];
    assign b_s = b_r[idx*SLICE_W +: SLICE_W];

    rca_slice #(
        .W (SLICE_W)
    ) u_slice (
        .c_out (slice_c),
        .sum   (slice_sum),
        .a     (a_s),
        .b     (b_s),
        .c_in  (carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b_in;
                        carry    <= carry_in;
                        idx      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    sum[idx*SLICE_W +: SLICE_W] <= slice_sum;
                    carry                       <= slice_c;
                    if (idx == LAST_IDX) begin
                        c_out     <= slice_c;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_add_sequencer.sv
// Self-checking bench for rca_add_sequencer against a plain-arithmetic add/subtract model.
module tb_rca_add_sequencer;

    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          c_in = 1'b0;
    logic          op_sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] sum;
    logic          c_out;
    logic          busy;

    int unsigned checks = 0;
    int unsigned errors = 0;

    rca_add_sequencer #(
        .DATA_W  (64),
        .SLICE_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef ADD_SEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW:0] model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                          input logic ci, input logic sub);
        logic [DW:0] r;
        if (sub) r = {1'b0, x} + {1'b0, ~y} + (DW+1)'(1);
        else     r = {1'b0, x} + {1'b0, y} + {{DW{1'b0}}, ci};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, presents one request for one edge, then scrambles inputs.
    task automatic send(input logic [DW-1:0] ta, input logic [DW-1:0] tb_v,
                        input logic tc, input logic ts);
        int unsigned n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_in_ready_timeout got %0b want 1", in_ready);
        end
        a = ta; b = tb_v; c_in = tc; op_sub = ts; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = 1'(($urandom));
    endtask

    // Called right after the accept edge; returns number of edges until out_valid.
    task automatic wait_result(output int unsigned lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL result_timeout got out_valid=%0b want 1", out_valid);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [DW:0] exp, input int unsigned lat);
        checks++;
        if ({c_out, sum} !== exp) begin
            errors++;
            $display("FAIL %s got c_out=%0b sum=%016h want c_out=%0b sum=%016h",
                     name, c_out, sum, exp[DW], exp[DW-1:0]);
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL %s_latency got %0d want 4", name, lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy, c_out} !== 4'b1000 || sum !== '0) begin
            errors++;
            $display("FAIL reset_state got rdy=%0b vld=%0b busy=%0b c=%0b sum=%016h want 1 0 0 0 0",
                     in_ready, out_valid, busy, c_out, sum);
        end
    endtask

    task automatic test_carry_chain();
        int unsigned lat;
        logic [DW-1:0] x, y;
        x = 64'hFFFF_FFFF_FFFF_FFFF; y = 64'hF000_0000_0000_0000;
        send(x, y, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_flags got busy=%0b rdy=%0b want 1 0", busy, in_ready);
        end
        wait_result(lat);
        check_result("msb_carry", {1'b1, 64'hEFFF_FFFF_FFFF_FFFF}, lat);
        consume();
        x = 64'h0000_0000_0000_FFFF; y = 64'h1;
        send(x, y, 1'b0, 1'b0);
        wait_result(lat);
        check_result("slice_carry", {1'b0, 64'h0000_0000_0001_0000}, lat);
        consume();
    endtask

    task automatic test_hold();
        int unsigned lat;
        logic [DW:0] exp;
        exp = model(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        wait_result(lat);
        check_result("all_ones_cin", exp, lat);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || {c_out, sum} !== exp) begin
                errors++;
                $display("FAIL hold_stable cyc %0d got vld=%0b rdy=%0b busy=%0b c=%0b sum=%016h want 1 0 1 %0b %016h",
                         i, out_valid, in_ready, busy, c_out, sum, exp[DW], exp[DW-1:0]);
            end
        end
        in_valid = 1'b0;
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release got vld=%0b rdy=%0b busy=%0b want 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int unsigned lat;
        send(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || c_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset got rdy=%0b vld=%0b busy=%0b c=%0b sum=%016h want 1 0 0 0 0",
                     in_ready, out_valid, busy, c_out, sum);
        end
        send(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
        wait_result(lat);
        check_result("after_reset", {1'b1, 64'h1111_1111_1111_1101}, lat);
        consume();
    endtask

    task automatic test_back_to_back();
        logic [DW:0] q[$];
        logic [DW:0] exp;
        int unsigned sent = 0;
        int unsigned recvd = 0;
        int unsigned cyc = 0;
        localparam int unsigned N = 2000;
        while ((sent < N || q.size() != 0) && cyc < 40000) begin
            in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       a = '1;
                1:       a = 64'(sent) * 64'h0001_0001_0001_0001;
                default: a = {$urandom, $urandom};
            endcase
            b    = ($urandom_range(0, 3) == 0) ? ~a : {$urandom, $urandom};
            c_in = 1'($urandom);
`ifdef ADD_SEQ_SUB_EN
            op_sub = 1'($urandom);
`else
            op_sub = 1'b0;
`endif
            #3;
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, c_in, op_sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious got result %016h want none", sum);
                end else begin
                    exp = q.pop_front();
                    if ({c_out, sum} !== exp) begin
                        errors++;
                        $display("FAIL b2b_result #%0d got c=%0b sum=%016h want c=%0b sum=%016h",
                                 recvd, c_out, sum, exp[DW], exp[DW-1:0]);
                    end
                end
                recvd++;
            end
            checks++;
            if (q.size() > 1) begin
                errors++;
                $display("FAIL b2b_outstanding got %0d want <=1", q.size());
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (recvd !== N || sent !== N) begin
            errors++;
            $display("FAIL b2b_count got sent=%0d recvd=%0d want %0d", sent, recvd, N);
        end
    endtask

`ifdef ADD_SEQ_SUB_EN
    task automatic test_sub();
        int unsigned lat;
        send(64'h2A, 64'h49, 1'b0, 1'b1);
        wait_result(lat);
        check_result("sub_borrow", {1'b0, 64'hFFFF_FFFF_FFFF_FFE1}, lat);
        consume();
        send(64'h49, 64'h2A, 1'b0, 1'b1);
        wait_result(lat);
        check_result("sub_noborrow", {1'b1, 64'h1F}, lat);
        consume();
    endtask
`endif

    initial begin
        test_reset();
        test_carry_chain();
        test_hold();
        test_reset_mid_run();
`ifdef ADD_SEQ_SUB_EN
        test_sub();
`endif
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
